clkgen_profile_sequencer: RTL and testbench
===========================================

Name: clkgen_profile_sequencer

Overview:
- Parametrised controller that reprograms the dynamic clock_generator from a writable table of NUM_PROFILES (M, D, O) profiles.
- Replaces hard-coded 4-entry frequency cycling with step, direct-select, lock supervision, timeout, retry and error reporting.
- Sits on the config clock domain, between control logic (button, host registers) and clock_generator.

Parameters:
- NUM_PROFILES, 4, number of table entries (>=2).
- IDX_W, 2, profile index width; must satisfy 2^IDX_W >= NUM_PROFILES.
- M_W, 7, multiplier field width.
- D_W, 4, divider field width.
- O_W, 8, output divider field width.
- START_LEN, 7, cycles cg_start is held high (>=1).
- TIMEOUT, 65535, max cycles allowed in each WAIT state.
- MAX_RETRY, 2, restarts attempted after a timeout before declaring error.

Ports:
- clk  in  1  config/system clock.
- rst_n  in  1  asynchronous active-low reset.
- prof_wr_en  in  1  table write strobe.
- prof_wr_idx  in  IDX_W  entry to write.
- prof_wr_m  in  M_W  M value to write.
- prof_wr_d  in  D_W  D value to write.
- prof_wr_o  in  O_W  O value to write.
- req_next  in  1  pulse: program (cur_idx+1) mod NUM_PROFILES.
- req_sel  in  1  pulse: program req_idx.
- req_idx  in  IDX_W  target for req_sel.
- cg_m  out  M_W  to clock_generator M.
- cg_d  out  D_W  to clock_generator D.
- cg_o  out  O_W  to clock_generator O.
- cg_start  out  1  to clock_generator start.
- cg_done  in  1  clock_generator program_done.
- cg_locked  in  1  clock_generator locked.
- busy  out  1  sequence in progress.
- cur_idx  out  IDX_W  last successfully locked profile.
- error  out  1  sticky failure flag.
- retry_cnt  out  2  retries used by the current/last sequence (saturating at 3).
- req_drop  out  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - Every table entry = M 7, D 4, O 100.
  - cg_m/cg_d/cg_o = 7/4/100.
  - cg_start, busy, error, req_drop = 0; cur_idx = 0; retry_cnt = 0.
  - No programming is issued after reset.
- Table write: at a clock edge with prof_wr_en and prof_wr_idx < NUM_PROFILES. Out-of-range writes are ignored. Writes never alter an in-flight sequence, because fields are latched at accept.
- Request accept (IDLE only, cg_done=1):
  - req_sel wins over simultaneous req_next.
  - Target latched into tgt_idx; cg_m/d/o load from the table the same edge; retry_cnt cleared; error cleared; busy=1 next cycle.
- Request reject: req_drop pulses for one cycle when a request arrives and any of these holds:
  - not IDLE;
  - IDLE with cg_done=0;
  - req_sel with req_idx >= NUM_PROFILES.
  - Otherwise no state change.
- States:
  - IDLE: described above.
  - START: cg_start=1 for exactly START_LEN cycles, then WAIT_DONE.
  - WAIT_DONE: wait for cg_done to fall then rise (a fresh completion). Go to WAIT_LOCK when cg_done=1 having been seen low since START began.
  - WAIT_LOCK: on cg_locked=1, go to IDLE with cur_idx<=tgt_idx and busy=0.
- Timeout: a single counter clears on entry to each WAIT state. If it reaches TIMEOUT in WAIT_DONE or WAIT_LOCK:
  - retry_cnt < MAX_RETRY: retry_cnt++, return to START with the same fields.
  - otherwise: error=1, busy=0, IDLE, cur_idx unchanged.
- Outputs:
  - cg_m/d/o stay stable from accept until the next accept.
  - cg_start is registered and never glitches.
  - busy=1 in START/WAIT_DONE/WAIT_LOCK.
- Wrap: req_next from cur_idx = NUM_PROFILES-1 targets 0.
- error clears only on reset or the next accepted request.
- Reset mid-sequence: immediate return to reset values; cg_start drops asynchronously.

Test Plan:
- Reset, then req_next with a model asserting cg_done low 3 cycles after start, high after 20 cycles, locked 10 cycles later -> cg_start high exactly 7 cycles; cg_m/d/o = 7/4/100; busy falls when locked rises; cur_idx=1; error=0.
- Write idx 3 = (42, 4, 25), then req_sel idx 3 -> cg_m/d/o = 42/4/25 on the accept edge; cur_idx=3 after lock. Follow with req_next -> target 0 (wrap).
- Issue req_next and req_sel idx 2 in the same cycle -> idx 2 programmed. A req_next during busy -> one-cycle req_drop and no state change. req_sel idx 4 with NUM_PROFILES=4 -> req_drop.
- Model never asserts locked, TIMEOUT=100 -> three cg_start bursts (1 + 2 retries); then error=1, retry_cnt=2, busy=0, cur_idx unchanged. Next valid request clears error.
- Write the target entry while in WAIT_LOCK -> cg_m/d/o unchanged until the next accept.
- Deassert rst_n mid-START -> cg_start=0 asynchronously; all outputs at reset values; table back to defaults.

Source files
------------

// File: rtl/clkgen_profile_sequencer_if.sv
// ---------------------------------------------------------------------------
// clkgen_profile_sequencer_if
// Bundles the profile-table write port, the request port, the clock_generator
// control/status lines and the sequencer status outputs.
//   master : control side (host/button logic plus the clock_generator model)
//   slave  : the sequencer itself
// Signals:
//   prof_wr_en/idx/m/d/o  table write strobe, entry index and field values
//   req_next, req_sel     step / direct-select request pulses, req_idx target
//   cg_m/cg_d/cg_o        fields presented to the clock_generator
//   cg_start              clock_generator start strobe
//   cg_done, cg_locked    clock_generator program_done / locked
//   busy, cur_idx, error, retry_cnt, req_drop   sequencer status
// ---------------------------------------------------------------------------
interface clkgen_profile_sequencer_if #(
    parameter int IDX_W = 2,
    parameter int M_W   = 7,
    parameter int D_W   = 4,
    parameter int O_W   = 8
);
    logic             prof_wr_en;
    logic [IDX_W-1:0] prof_wr_idx;
    logic [M_W-1:0]   prof_wr_m;
    logic [D_W-1:0]   prof_wr_d;
    logic [O_W-1:0]   prof_wr_o;
    logic             req_next;
    logic             req_sel;
    logic [IDX_W-1:0] req_idx;
    logic [M_W-1:0]   cg_m;
    logic [D_W-1:0]   cg_d;
    logic [O_W-1:0]   cg_o;
    logic             cg_start;
    logic             cg_done;
    logic             cg_locked;
    logic             busy;
    logic [IDX_W-1:0] cur_idx;
    logic             error;
    logic [1:0]       retry_cnt;
    logic             req_drop;

    modport master (
        output prof_wr_en, prof_wr_idx, prof_wr_m, prof_wr_d, prof_wr_o,
        output req_next, req_sel, req_idx, cg_done, cg_locked,
        input  cg_m, cg_d, cg_o, cg_start, busy, cur_idx, error, retry_cnt, req_drop
    );

    modport slave (
        input  prof_wr_en, prof_wr_idx, prof_wr_m, prof_wr_d, prof_wr_o,
        input  req_next, req_sel, req_idx, cg_done, cg_locked,
        output cg_m, cg_d, cg_o, cg_start, busy, cur_idx, error, retry_cnt, req_drop
    );
endinterface

// File: rtl/clkgen_profile_sequencer.sv
// ---------------------------------------------------------------------------
// clkgen_profile_sequencer
// Reprograms the dynamic clock_generator from a writable table of
// NUM_PROFILES (M, D, O) profiles. A request (step or direct select) is
// accepted only when idle and the generator reports done; the selected
// fields are latched onto cg_m/cg_d/cg_o, cg_start is pulsed for START_LEN
// cycles, then a fresh done and lock are awaited. Each wait is bounded by
// TIMEOUT cycles; a timeout restarts the sequence up to MAX_RETRY times and
// then raises the sticky error flag.
// Ports:
//   clk    config clock
//   rst_n  asynchronous active-low reset
//   bus    clkgen_profile_sequencer_if.slave (table write, requests,
//          clock_generator interface, status)
// ---------------------------------------------------------------------------
module clkgen_profile_sequencer #(
    parameter int NUM_PROFILES = 4,
    parameter int IDX_W        = 2,
    parameter int M_W          = 7,
    parameter int D_W          = 4,
    parameter int O_W          = 8,
    parameter int START_LEN    = 7,
    parameter int TIMEOUT      = 65535,
    parameter int MAX_RETRY    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    clkgen_profile_sequencer_if.slave        bus
);
    localparam int TBL_W = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1;
    localparam int SL_W  = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [M_W-1:0] DEF_M = M_W'(7);
    localparam logic [D_W-1:0] DEF_D = D_W'(4);
    localparam logic [O_W-1:0] DEF_O = O_W'(100);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, WAIT_LOCK} state_t;

    logic [M_W-1:0] tbl_m [NUM_PROFILES];
    logic [D_W-1:0] tbl_d [NUM_PROFILES];
    logic [O_W-1:0] tbl_o [NUM_PROFILES];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] tgt_q, tgt_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [M_W-1:0]   m_q, m_d;
    logic [D_W-1:0]   d_q, d_d;
    logic [O_W-1:0]   o_q, o_d;
    logic [SL_W-1:0]  st_cnt_q, st_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             seen_low_q, seen_low_d;
    logic [1:0]       retry_q, retry_d;
    logic             err_q, err_d;
    logic             drop_q, drop_d;
    logic             start_q, busy_q;

    logic             any_req, sel_ok, wr_ok, to_hit, expire;
    logic [IDX_W-1:0] next_idx, sel_idx;
    logic [TBL_W-1:0] rd_idx;

    assign wr_ok    = int'(bus.prof_wr_idx) < NUM_PROFILES;
    assign any_req  = bus.req_sel | bus.req_next;
    assign sel_ok   = !bus.req_sel || (int'(bus.req_idx) < NUM_PROFILES);
    assign next_idx = (cur_q == IDX_W'(NUM_PROFILES - 1)) ? '0 : cur_q + IDX_W'(1);
    assign sel_idx  = bus.req_sel ? bus.req_idx : next_idx;
    assign rd_idx   = TBL_W'(sel_idx);
    assign to_hit   = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                tbl_m[i] <= DEF_M;
                tbl_d[i] <= DEF_D;
                tbl_o[i] <= DEF_O;
            end
        end else if (bus.prof_wr_en && wr_ok) begin
            tbl_m[TBL_W'(bus.prof_wr_idx)] <= bus.prof_wr_m;
            tbl_d[TBL_W'(bus.prof_wr_idx)] <= bus.prof_wr_d;
            tbl_o[TBL_W'(bus.prof_wr_idx)] <= bus.prof_wr_o;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cur_d      = cur_q;
        m_d        = m_q;
        d_d        = d_q;
        o_d        = o_q;
        st_cnt_d   = st_cnt_q;
        to_cnt_d   = to_cnt_q;
        // Remembers a low cg_done since START began so only a fresh
        // completion (fall then rise) advances WAIT_DONE.
        seen_low_d = seen_low_q | ~bus.cg_done;
        retry_d    = retry_q;
        err_d      = err_q;
        drop_d     = 1'b0;
        expire     = 1'b0;

        if (any_req && state_q != IDLE) drop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (bus.cg_done && sel_ok) begin
                        tgt_d      = sel_idx;
                        m_d        = tbl_m[rd_idx];
                        d_d        = tbl_d[rd_idx];
                        o_d        = tbl_o[rd_idx];
                        retry_d    = 2'd0;
                        err_d      = 1'b0;
                        st_cnt_d   = SL_W'(START_LEN - 1);
                        seen_low_d = 1'b0;
                        state_d    = START;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            START: begin
                if (st_cnt_q == '0) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end else begin
                    st_cnt_d = st_cnt_q - SL_W'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.cg_done && seen_low_q) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_LOCK;
                end else if (to_hit) begin
                    expire = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (bus.cg_locked) begin
                    cur_d   = tgt_q;
                    state_d = IDLE;
                end else if (to_hit) begin
                    expire = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Retry keeps the latched fields; only the start burst is replayed.
        if (expire) begin
            if (int'(retry_q) < MAX_RETRY) begin
                retry_d    = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
                st_cnt_d   = SL_W'(START_LEN - 1);
                seen_low_d = 1'b0;
                state_d    = START;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // cg_start and busy are registered from the next state so they are
    // glitch-free and line up exactly with the START / non-IDLE states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            cur_q      <= '0;
            m_q        <= DEF_M;
            d_q        <= DEF_D;
            o_q        <= DEF_O;
            st_cnt_q   <= '0;
            to_cnt_q   <= '0;
            seen_low_q <= 1'b0;
            retry_q    <= 2'd0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            cur_q      <= cur_d;
            m_q        <= m_d;
            d_q        <= d_d;
            o_q        <= o_d;
            st_cnt_q   <= st_cnt_d;
            to_cnt_q   <= to_cnt_d;
            seen_low_q <= seen_low_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            start_q    <= (state_d == START);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign bus.cg_m      = m_q;
    assign bus.cg_d      = d_q;
    assign bus.cg_o      = o_q;
    assign bus.cg_start  = start_q;
    assign bus.busy      = busy_q;
    assign bus.cur_idx   = cur_q;
    assign bus.error     = err_q;
    assign bus.retry_cnt = retry_q;
    assign bus.req_drop  = drop_q;
endmodule

// File: tb/tb_clkgen_profile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clkgen_profile_sequencer
// Directed bench for clkgen_profile_sequencer with a behavioural
// clock_generator model (done falls 3 cycles after start, rises at 20,
// locked at 30 when enabled). Expected sequence outcomes are queued when a
// request is issued and compared when busy falls.
// ---------------------------------------------------------------------------
module tb_clkgen_profile_sequencer;
    localparam int NP = 4;
    localparam int IW = 3;
    localparam int TO = 100;
    localparam int SL = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    clkgen_profile_sequencer_if #(.IDX_W(IW)) bus ();

    clkgen_profile_sequencer #(
        .NUM_PROFILES(NP), .IDX_W(IW), .M_W(7), .D_W(4), .O_W(8),
        .START_LEN(SL), .TIMEOUT(TO), .MAX_RETRY(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]    m;
        logic [3:0]    d;
        logic [7:0]    o;
        logic [IW-1:0] cur;
        logic          err;
        logic [1:0]    retry;
        int            bursts;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    logic [6:0]    tm [NP];
    logic [3:0]    td [NP];
    logic [7:0]    tom[NP];
    logic [IW-1:0] mcur;

    // clock_generator model
    bit done_int   = 1'b1;
    bit force_low  = 1'b0;
    bit lock_en    = 1'b1;
    bit prev_start = 1'b0;
    int cg_cnt     = -1;
    int bursts     = 0;
    int burst_base = 0;
    int run_len    = 0;
    int len_min    = 99;
    int len_max    = 0;

    assign bus.cg_done = done_int & ~force_low;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_int      = 1'b1;
            bus.cg_locked = 1'b0;
            cg_cnt        = -1;
            prev_start    = 1'b0;
            run_len       = 0;
        end else begin
            if (bus.cg_start) run_len++;
            else if (prev_start) begin
                if (run_len < len_min) len_min = run_len;
                if (run_len > len_max) len_max = run_len;
                run_len = 0;
            end
            if (bus.cg_start && !prev_start) begin
                cg_cnt        = 0;
                bursts++;
                bus.cg_locked = 1'b0;
            end else if (cg_cnt >= 0) begin
                cg_cnt++;
            end
            prev_start = bus.cg_start;
            if (cg_cnt == 3)  done_int = 1'b0;
            if (cg_cnt == 20) done_int = 1'b1;
            if (cg_cnt == 30 && lock_en) bus.cg_locked = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            tm[i] = 7'd7; td[i] = 4'd4; tom[i] = 8'd100;
        end
        mcur = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_m"}, bus.cg_m, 7);
        check({tag, "_d"}, bus.cg_d, 4);
        check({tag, "_o"}, bus.cg_o, 100);
        check({tag, "_start"}, bus.cg_start, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_err"}, bus.error, 0);
        check({tag, "_cur"}, bus.cur_idx, 0);
        check({tag, "_retry"}, bus.retry_cnt, 0);
        check({tag, "_drop"}, bus.req_drop, 0);
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [6:0] m,
                      input logic [3:0] d, input logic [7:0] o);
        bus.prof_wr_en = 1'b1; bus.prof_wr_idx = idx;
        bus.prof_wr_m = m; bus.prof_wr_d = d; bus.prof_wr_o = o;
        tick(1);
        bus.prof_wr_en = 1'b0;
        if (int'(idx) < NP) begin
            tm[idx[1:0]] = m; td[idx[1:0]] = d; tom[idx[1:0]] = o;
        end
    endtask

    task automatic issue(input bit sel, input bit nxt, input logic [IW-1:0] idx);
        exp_t e;
        logic [IW-1:0] t;
        t = sel ? idx : ((mcur == IW'(NP - 1)) ? '0 : mcur + IW'(1));
        e.m = tm[t[1:0]]; e.d = td[t[1:0]]; e.o = tom[t[1:0]];
        e.err    = !lock_en;
        e.retry  = lock_en ? 2'd0 : 2'd2;
        e.bursts = lock_en ? 1 : 3;
        e.cur    = lock_en ? t : mcur;
        if (lock_en) mcur = t;
        sbq.push_back(e);
        burst_base = bursts; len_min = 99; len_max = 0;
        bus.req_sel = sel; bus.req_next = nxt; bus.req_idx = idx;
        tick(1);
        bus.req_sel = 1'b0; bus.req_next = 1'b0;
        check("acc_drop", bus.req_drop, 0);
        check("acc_busy", bus.busy, 1);
        check("acc_m", bus.cg_m, e.m);
        check("acc_d", bus.cg_d, e.d);
        check("acc_o", bus.cg_o, e.o);
        check("acc_err", bus.error, 0);
        check("acc_retry", bus.retry_cnt, 0);
    endtask

    task automatic finish_seq(input string tag);
        exp_t e;
        int n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
        check({tag, "_idle"}, bus.busy, 0);
        check({tag, "_sbq"}, sbq.size(), 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({tag, "_m"}, bus.cg_m, e.m);
            check({tag, "_d"}, bus.cg_d, e.d);
            check({tag, "_o"}, bus.cg_o, e.o);
            check({tag, "_cur"}, bus.cur_idx, e.cur);
            check({tag, "_err"}, bus.error, e.err);
            check({tag, "_retry"}, bus.retry_cnt, e.retry);
            check({tag, "_bursts"}, bursts - burst_base, e.bursts);
            check({tag, "_startlen_min"}, len_min, SL);
            check({tag, "_startlen_max"}, len_max, SL);
            check({tag, "_start"}, bus.cg_start, 0);
            check({tag, "_locked"}, bus.cg_locked, e.err ? 0 : 1);
        end
    endtask

    initial begin
        int n;
        bus.prof_wr_en = 1'b0; bus.prof_wr_idx = '0;
        bus.prof_wr_m = '0; bus.prof_wr_d = '0; bus.prof_wr_o = '0;
        bus.req_next = 1'b0; bus.req_sel = 1'b0; bus.req_idx = '0;
        bus.cg_locked = 1'b0;
        model_reset();

        #1 rst_n = 1'b0;
        #1 check_reset("rst");
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("no_auto_start", bursts, 0);
        check("no_auto_busy", bus.busy, 0);

        // step from reset: target 1 with default fields
        issue(1'b0, 1'b1, '0);
        finish_seq("step1");

        // program entry 3, select it, then wrap back to 0
        wr(3'd3, 7'd42, 4'd4, 8'd25);
        issue(1'b1, 1'b0, 3'd3);
        finish_seq("sel3");
        issue(1'b0, 1'b1, '0);
        finish_seq("wrap");

        // simultaneous step and select: select wins
        issue(1'b1, 1'b1, 3'd2);
        tick(2);
        bus.req_next = 1'b1;
        tick(1);
        bus.req_next = 1'b0;
        check("busy_drop", bus.req_drop, 1);
        check("busy_drop_busy", bus.busy, 1);
        check("busy_drop_m", bus.cg_m, tm[2]);
        tick(1);
        check("busy_drop_pulse", bus.req_drop, 0);
        finish_seq("both");

        // out-of-range select is rejected
        bus.req_sel = 1'b1; bus.req_idx = 3'd4;
        tick(1);
        bus.req_sel = 1'b0;
        check("oor_sel_drop", bus.req_drop, 1);
        check("oor_sel_busy", bus.busy, 0);
        tick(1);
        check("oor_sel_pulse", bus.req_drop, 0);

        // idle but generator not done: rejected
        force_low = 1'b1;
        bus.req_next = 1'b1;
        tick(1);
        bus.req_next = 1'b0;
        check("notdone_drop", bus.req_drop, 1);
        check("notdone_busy", bus.busy, 0);
        force_low = 1'b0;
        tick(1);

        // out-of-range write must not alias onto entry 1
        wr(3'd5, 7'd99, 4'd9, 8'd9);
        issue(1'b1, 1'b0, 3'd1);
        finish_seq("oor_wr");

        // no lock: initial start plus two retries, then error
        lock_en = 1'b0;
        issue(1'b0, 1'b1, '0);
        finish_seq("timeout");
        lock_en = 1'b1;
        issue(1'b1, 1'b0, 3'd0);
        finish_seq("recover");

        // table write during WAIT_LOCK leaves the live fields alone
        issue(1'b1, 1'b0, 3'd1);
        n = 0;
        while (cg_cnt < 25 && n < 200) begin
            tick(1);
            n++;
        end
        check("wl_reach", (cg_cnt >= 25) ? 1 : 0, 1);
        check("wl_busy", bus.busy, 1);
        wr(3'd1, 7'd11, 4'd2, 8'd33);
        check("wl_m", bus.cg_m, 7);
        check("wl_d", bus.cg_d, 4);
        check("wl_o", bus.cg_o, 100);
        finish_seq("wl");
        issue(1'b1, 1'b0, 3'd1);
        finish_seq("wl_next");

        // reset in the middle of a start burst
        bus.req_next = 1'b1;
        tick(1);
        bus.req_next = 1'b0;
        check("mr_start_hi", bus.cg_start, 1);
        tick(2);
        #2 rst_n = 1'b0;
        #1 check_reset("mr");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        issue(1'b1, 1'b0, 3'd3);
        finish_seq("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
